// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: IDLE/RUN/STALL/FLUSH FSM with branch redirect, link capture and flush bubbles.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining FETCH_SEQ_PERF_CNT_EN.
module fetch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [1:0]  branch_type,
    input  logic [15:0] br_pc,
    input  logic [7:0]  cond_address,
    input  logic [10:0] uncond_address,
    input  logic [15:0] register_data_2,
    input  logic        link,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic        flush,
    output logic [15:0] link_pc,
    output logic        link_we,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FLUSH = 2'b11
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state_r, state_nxt_s;
    logic [15:0] pc_r, pc_nxt_s;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic        pc_we_r, pc_we_nxt_s;
    logic        flush_r, flush_nxt_s;
    logic        link_we_r, link_we_nxt_s;
    logic [15:0] link_pc_r, link_pc_nxt_s;
    logic        redirect_s;
    logic        take_redirect_s;
    logic [15:0] target_s;

    // Decode the resolving branch into a redirect request and its target
    always_comb begin
        redirect_s = 1'b0;
        target_s   = register_data_2;
        case (branch_type)
            2'b01: begin
                redirect_s = br_valid & br_taken;
                target_s   = br_pc + 16'd1 + {{8{cond_address[7]}}, cond_address};
            end
            2'b10: begin
                redirect_s = br_valid;
                target_s   = br_pc + 16'd1 + {{5{uncond_address[10]}}, uncond_address};
            end
            2'b11: begin
                redirect_s = br_valid;
                target_s   = register_data_2;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = register_data_2;
            end
        endcase
    end

    // IDLE always proceeds to RUN, so a branch there is dropped
    assign take_redirect_s = redirect_s & (state_r != IDLE);

    // Next-state and next-output logic; a redirect overrides stall and flush countdown
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        cnt_nxt_s     = cnt_r;
        pc_we_nxt_s   = 1'b0;
        flush_nxt_s   = 1'b0;
        link_we_nxt_s = 1'b0;
        link_pc_nxt_s = link_pc_r;
        if (take_redirect_s) begin
            state_nxt_s   = FLUSH;
            pc_nxt_s      = target_s;
            cnt_nxt_s     = FLUSH_INIT;
            pc_we_nxt_s   = 1'b1;
            flush_nxt_s   = 1'b1;
            link_we_nxt_s = link;
            link_pc_nxt_s = link ? (br_pc + 16'd1) : link_pc_r;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = RUN;
                    pc_we_nxt_s = 1'b1;
                end
                RUN, STALL: begin
                    if (stall_req) begin
                        state_nxt_s = STALL;
                    end else begin
                        state_nxt_s = RUN;
                        pc_nxt_s    = pc_r + 16'd1;
                        pc_we_nxt_s = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_nxt_s    = pc_r + 16'd1;
                    pc_we_nxt_s = 1'b1;
                    if (cnt_r <= 3'd1) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r - 3'd1;
                        flush_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            pc_r      <= 16'h0000;
            cnt_r     <= 3'd0;
            pc_we_r   <= 1'b0;
            flush_r   <= 1'b0;
            link_we_r <= 1'b0;
            link_pc_r <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pc_we_r   <= pc_we_nxt_s;
            flush_r   <= flush_nxt_s;
            link_we_r <= link_we_nxt_s;
            link_pc_r <= link_pc_nxt_s;
        end
    end

    assign pc_out  = pc_r;
    assign pc_we   = pc_we_r;
    assign flush   = flush_r;
    assign link_pc = link_pc_r;
    assign link_we = link_we_r;
    assign state   = state_r;

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating residency counters for STALL and FLUSH
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if ((state_r == STALL) && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((state_r == FLUSH) && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default FLUSH_CYCLES=2).
// Counter expectations follow FETCH_SEQ_PERF_CNT_EN when the bench is built with it.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall_req;
    logic        br_valid;
    logic        br_taken;
    logic [1:0]  branch_type;
    logic [15:0] br_pc;
    logic [7:0]  cond_address;
    logic [10:0] uncond_address;
    logic [15:0] register_data_2;
    logic        link;
    logic [15:0] pc_out;
    logic        pc_we;
    logic        flush;
    logic [15:0] link_pc;
    logic        link_we;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .br_valid(br_valid),
        .br_taken(br_taken), .branch_type(branch_type), .br_pc(br_pc),
        .cond_address(cond_address), .uncond_address(uncond_address),
        .register_data_2(register_data_2), .link(link), .pc_out(pc_out),
        .pc_we(pc_we), .flush(flush), .link_pc(link_pc), .link_we(link_we),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_req = 1'b0; br_valid = 1'b0; br_taken = 1'b0; branch_type = 2'b00;
        br_pc = 16'h0000; cond_address = 8'h00; uncond_address = 11'h000;
        register_data_2 = 16'h0000; link = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        // inputs asserted while in reset must be ignored
        br_valid = 1'b1; branch_type = 2'b11; register_data_2 = 16'hBEEF; link = 1'b1; stall_req = 1'b1;
        tick();
        tick();
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", pc_out); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b exp 00", state); end
        checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we: got %b exp 0", pc_we); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", flush); end
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL reset_link_we: got %b exp 0", link_we); end
        checks++; if (link_pc !== 16'h0000) begin errors++; $display("FAIL reset_link_pc: got %h exp 0000", link_pc); end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall_cnt: got %h exp 0000", stall_cnt); end
        checks++; if (flush_cnt !== 16'h0000) begin errors++; $display("FAIL reset_flush_cnt: got %h exp 0000", flush_cnt); end
        clear_inputs();
    endtask

    task automatic test_run();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL run_pc[%0d]: got %h exp %h", i, pc_out, 16'(i)); end
            checks++; if (pc_we !== 1'b1 || state !== 2'b01) begin errors++; $display("FAIL run_we_state[%0d]: got %b/%b exp 1/01", i, pc_we, state); end
        end
    endtask

    task automatic test_stall();
        tick();
        tick();
        checks++; if (pc_out !== 16'h0005) begin errors++; $display("FAIL stall_pre_pc: got %h exp 0005", pc_out); end
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== 16'h0005 || pc_we !== 1'b0 || state !== 2'b10) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc=%h we=%b st=%b exp pc=0005 we=0 st=10", i, pc_out, pc_we, state);
            end
        end
        stall_req = 1'b0;
        tick();
        checks++; if (pc_out !== 16'h0006 || pc_we !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL stall_release: got pc=%h we=%b st=%b exp pc=0006 we=1 st=01", pc_out, pc_we, state);
        end
        checks++; if (stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stall_cnt: got %h exp %h", stall_cnt, (PERF ? 16'd3 : 16'd0)); end
    endtask

    task automatic test_cond_branch();
        // not-taken conditional and type 00 are no-ops
        br_valid = 1'b1; branch_type = 2'b01; br_taken = 1'b0; br_pc = 16'h0010; cond_address = 8'hFC;
        tick();
        checks++; if (pc_out !== 16'h0007 || flush !== 1'b0) begin errors++; $display("FAIL cond_not_taken: got pc=%h fl=%b exp pc=0007 fl=0", pc_out, flush); end
        branch_type = 2'b00; br_taken = 1'b1;
        tick();
        checks++; if (pc_out !== 16'h0008 || flush !== 1'b0) begin errors++; $display("FAIL type_none: got pc=%h fl=%b exp pc=0008 fl=0", pc_out, flush); end
        branch_type = 2'b01;
        tick();
        clear_inputs();
        checks++; if (pc_out !== 16'h000D || flush !== 1'b1 || state !== 2'b11 || link_we !== 1'b0) begin
            errors++; $display("FAIL cond_target: got pc=%h fl=%b st=%b lw=%b exp pc=000d fl=1 st=11 lw=0", pc_out, flush, state, link_we);
        end
        tick();
        checks++; if (pc_out !== 16'h000E || flush !== 1'b1) begin errors++; $display("FAIL cond_flush2: got pc=%h fl=%b exp pc=000e fl=1", pc_out, flush); end
        tick();
        checks++; if (pc_out !== 16'h000F || flush !== 1'b0 || state !== 2'b01) begin
            errors++; $display("FAIL cond_back_run: got pc=%h fl=%b st=%b exp pc=000f fl=0 st=01", pc_out, flush, state);
        end
    endtask

    task automatic test_reg_link_stall();
        br_valid = 1'b1; branch_type = 2'b11; register_data_2 = 16'h1234; link = 1'b1; br_pc = 16'h0040; stall_req = 1'b1;
        tick();
        clear_inputs();
        checks++; if (pc_out !== 16'h1234 || state !== 2'b11 || pc_we !== 1'b1) begin
            errors++; $display("FAIL reg_target: got pc=%h st=%b we=%b exp pc=1234 st=11 we=1", pc_out, state, pc_we);
        end
        checks++; if (link_pc !== 16'h0041 || link_we !== 1'b1) begin errors++; $display("FAIL link_pulse: got lp=%h lw=%b exp lp=0041 lw=1", link_pc, link_we); end
        tick();
        checks++; if (link_we !== 1'b0 || link_pc !== 16'h0041 || pc_out !== 16'h1235) begin
            errors++; $display("FAIL link_hold: got lw=%b lp=%h pc=%h exp lw=0 lp=0041 pc=1235", link_we, link_pc, pc_out);
        end
        tick();
        checks++; if (pc_out !== 16'h1236 || state !== 2'b01) begin errors++; $display("FAIL reg_back_run: got pc=%h st=%b exp pc=1236 st=01", pc_out, state); end
    endtask

    task automatic test_wrap();
        br_valid = 1'b1; branch_type = 2'b11; register_data_2 = 16'hFFFD;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (pc_out !== 16'hFFFF || state !== 2'b01) begin errors++; $display("FAIL wrap_pre: got pc=%h st=%b exp pc=ffff st=01", pc_out, state); end
        tick();
        checks++; if (pc_out !== 16'h0000 || pc_we !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h we=%b exp pc=0000 we=1", pc_out, pc_we); end
        br_valid = 1'b1; branch_type = 2'b10; br_pc = 16'hFFFF; uncond_address = 11'h000;
        tick();
        checks++; if (pc_out !== 16'h0000 || flush !== 1'b1) begin errors++; $display("FAIL uncond_wrap: got pc=%h fl=%b exp pc=0000 fl=1", pc_out, flush); end
        br_pc = 16'h0100; uncond_address = 11'h7FF;
        tick();
        checks++; if (pc_out !== 16'h0100) begin errors++; $display("FAIL uncond_neg: got %h exp 0100", pc_out); end
        uncond_address = 11'h3FF;
        tick();
        clear_inputs();
        checks++; if (pc_out !== 16'h0500) begin errors++; $display("FAIL uncond_pos: got %h exp 0500", pc_out); end
        tick();
        tick();
    endtask

    task automatic test_flush_restart();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        br_valid = 1'b1; branch_type = 2'b10; br_pc = 16'h0020; uncond_address = 11'h010;
        tick();
        checks++; if (pc_out !== 16'h0031 || flush !== 1'b1) begin errors++; $display("FAIL restart_first: got pc=%h fl=%b exp pc=0031 fl=1", pc_out, flush); end
        branch_type = 2'b11; register_data_2 = 16'h0200; stall_req = 1'b1;
        tick();
        br_valid = 1'b0;
        checks++; if (pc_out !== 16'h0200 || flush !== 1'b1 || state !== 2'b11) begin
            errors++; $display("FAIL restart_second: got pc=%h fl=%b st=%b exp pc=0200 fl=1 st=11", pc_out, flush, state);
        end
        tick();
        checks++; if (pc_out !== 16'h0201 || flush !== 1'b1 || state !== 2'b11) begin
            errors++; $display("FAIL restart_hold: got pc=%h fl=%b st=%b exp pc=0201 fl=1 st=11", pc_out, flush, state);
        end
        tick();
        clear_inputs();
        checks++; if (pc_out !== 16'h0202 || flush !== 1'b0 || state !== 2'b01) begin
            errors++; $display("FAIL restart_end: got pc=%h fl=%b st=%b exp pc=0202 fl=0 st=01", pc_out, flush, state);
        end
        checks++; if (flush_cnt !== (PERF ? 16'd3 : 16'd0)) begin errors++; $display("FAIL flush_cnt: got %h exp %h", flush_cnt, (PERF ? 16'd3 : 16'd0)); end
    endtask

    task automatic test_reset_mid_flush();
        br_valid = 1'b1; branch_type = 2'b11; register_data_2 = 16'h0777; link = 1'b1; br_pc = 16'h0300;
        tick();
        checks++; if (link_we !== 1'b1 || state !== 2'b11) begin errors++; $display("FAIL pre_reset_flush: got lw=%b st=%b exp lw=1 st=11", link_we, state); end
        reset = 1'b0;
        tick();
        checks++; if (pc_out !== 16'h0000 || state !== 2'b00 || flush !== 1'b0 || link_we !== 1'b0 || link_pc !== 16'h0000) begin
            errors++; $display("FAIL mid_flush_reset: got pc=%h st=%b fl=%b lw=%b lp=%h exp 0000/00/0/0/0000", pc_out, state, flush, link_we, link_pc);
        end
        checks++; if (stall_cnt !== 16'h0000 || flush_cnt !== 16'h0000) begin
            errors++; $display("FAIL mid_flush_cnts: got %h/%h exp 0000/0000", stall_cnt, flush_cnt);
        end
        clear_inputs();
        reset = 1'b1;
        tick();
        checks++; if (pc_out !== 16'h0000 || state !== 2'b01 || flush !== 1'b0 || link_we !== 1'b0) begin
            errors++; $display("FAIL post_reset_run: got pc=%h st=%b fl=%b lw=%b exp 0000/01/0/0", pc_out, state, flush, link_we);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_cond_branch();
        test_reg_link_stall();
        test_wrap();
        test_flush_restart();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the bubble cycles after a redirect (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port stall_req, input, 1 bit: decode hazard; hold the PC.
REQ-005 SHALL have port br_valid, input, 1 bit: branch resolved this cycle.
REQ-006 SHALL have port br_taken, input, 1 bit: conditional branch outcome.
REQ-007 SHALL have port branch_type, input, 2 bits: 00 none, 01 conditional, 10 unconditional, 11 register.
REQ-008 SHALL have port br_pc, input, 16 bits: PC of the resolving branch.
REQ-009 SHALL have port cond_address, input, 8 bits: signed conditional offset.
REQ-010 SHALL have port uncond_address, input, 11 bits: signed unconditional offset.
REQ-011 SHALL have port register_data_2, input, 16 bits: absolute register-branch target.
REQ-012 SHALL have port link, input, 1 bit: the branch writes a link.
REQ-013 SHALL have port pc_out, output, 16 bits: fetch PC (registered).
REQ-014 SHALL have port pc_we, output, 1 bit: instruction fetched this cycle.
REQ-015 SHALL have port flush, output, 1 bit: squash IF/ID and ID/EX.
REQ-016 SHALL have port link_pc, output, 16 bits: return address.
REQ-017 SHALL have port link_we, output, 1 bit: link_pc valid pulse.
REQ-018 SHALL have port state, output, 2 bits: FSM encoding (debug).

Function
REQ-019 redirect = br_valid & (branch_type==10 | branch_type==11 | (branch_type==01 & br_taken)); all other br_valid cycles SHALL have no effect.
REQ-020 Target: type 01 = br_pc+1+sext(cond_address); type 10 = br_pc+1+sext(uncond_address); type 11 = register_data_2; all sums modulo 2^16, carry discarded.
REQ-021 FSM states SHALL be IDLE=00, RUN=01, STALL=10, FLUSH=11.
REQ-022 IDLE: pc_we=0, PC held; go to RUN the next cycle unconditionally.
REQ-023 RUN: pc_we=1, pc_out increments by 1 per cycle; 0xFFFF wraps to 0x0000.
REQ-024 RUN with stall_req=1 and no redirect: go to STALL; the PC is held that cycle.
REQ-025 STALL: pc_we=0, PC held; return to RUN in the cycle after stall_req falls.
REQ-026 Redirect in RUN, STALL or FLUSH: next cycle pc_out=target, state=FLUSH, flush counter=FLUSH_CYCLES.
REQ-027 FLUSH: flush=1; pc_we=1; PC increments from target; counter decrements; return to RUN after FLUSH_CYCLES cycles.
REQ-028 Redirect arriving during FLUSH SHALL restart the counter at FLUSH_CYCLES with the new target.
REQ-029 Redirect and stall_req in the same cycle: redirect wins; stall_req is ignored that cycle.
REQ-030 stall_req during FLUSH SHALL be ignored.
REQ-031 Redirect with link=1: link_pc=br_pc+1 (mod 2^16), link_we=1 for exactly one cycle, coincident with pc_out=target; otherwise link_we=0 and link_pc holds.
REQ-032 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-033 reset=0 at a clock edge: pc_out=0x0000, state=IDLE, flush=0, pc_we=0, link_we=0, link_pc=0x0000, flush counter=0, perf counters=0.
REQ-034 Reset mid-FLUSH or mid-STALL SHALL abandon the operation; no pending redirect or link survives reset.
REQ-035 Inputs SHALL be ignored while reset=0.

Configuration
REQ-036 Macro FETCH_SEQ_PERF_CNT_EN defined: add outputs stall_cnt[15:0] and flush_cnt[15:0], counting cycles in STALL and FLUSH respectively, saturating at 0xFFFF and cleared by reset.
REQ-037 Macro FETCH_SEQ_PERF_CNT_EN undefined: both ports still exist and are tied to 0x0000, with no counter logic.

Verification
REQ-038 Release reset, no stimulus -> one IDLE cycle, then pc_out 0,1,2,3 with pc_we=1.
REQ-039 At pc_out=5, stall_req high 3 cycles -> pc_out held at 5 with pc_we=0 for 3 cycles, then 6.
REQ-040 br_valid, type 01, br_taken, br_pc=0x0010, cond_address=0xFC -> pc_out=0x000D; flush=1 for 2 cycles; then RUN.
REQ-041 Type 11, register_data_2=0x1234, link=1, br_pc=0x0040, stall_req=1 same cycle -> pc_out=0x1234, link_pc=0x0041, link_we pulses once, stall ignored.
REQ-042 pc_out=0xFFFF in RUN -> next pc_out=0x0000; type 10 with br_pc=0xFFFF and uncond_address=0x000 -> target 0x0000.
REQ-043 Second redirect one cycle into FLUSH -> counter restarts and flush stays high for 2 further cycles; with FETCH_SEQ_PERF_CNT_EN, flush_cnt=3.
